// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: steers the HPS ioctl download stream into four ROM
// regions, counts accepted bytes, and holds the core in reset until a
// correctly sized image has arrived and a settle delay has elapsed.
module rom_load_sequencer #(
    parameter logic [16:0] BASE1         = 17'h08000,
    parameter logic [16:0] BASE2         = 17'h0C000,
    parameter logic [16:0] BASE3         = 17'h0C120,
    parameter logic [16:0] TOTAL_LEN     = 17'h0C220,
    parameter int          SETTLE_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic [3:0]  rom_sel,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        rom_wr,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [16:0] byte_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN,
        ERR
    } state_t;

    // Counter only ever holds SETTLE_CYCLES-1 down to 0.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_RELOAD = CW'(SETTLE_CYCLES - 1);

    state_t        state;
    state_t        state_next;

    logic          dl_q;
    logic          wr_q;
    logic [24:0]   addr_q;
    logic [7:0]    dout_q;

    logic          overflow;
    logic [CW-1:0] settle_cnt;

    logic          rise;
    logic          fall;
    logic          in_range;
    logic          accept;
    logic          drop;
    logic [16:0]   count_inc;
    logic [16:0]   count_after;
    logic          ovf_after;
    logic          image_ok;
    logic          load_entry;

    logic [16:0]   addr_low;
    logic [16:0]   region_base;
    logic [16:0]   local_addr;
    logic [3:0]    sel_dec;

    // Input capture stage; dl_q resets high so a download already in
    // progress when reset releases is not mistaken for a new rising edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_q   <= 1'b1;
            wr_q   <= 1'b0;
            addr_q <= '0;
            dout_q <= '0;
        end else begin
            dl_q   <= ioctl_download;
            wr_q   <= ioctl_wr;
            addr_q <= ioctl_addr;
            dout_q <= ioctl_dout;
        end
    end

    assign rise      = ioctl_download & ~dl_q;
    assign fall      = ~ioctl_download & dl_q;
    assign addr_low  = addr_q[16:0];
    assign in_range  = (addr_q[24:17] == 8'd0) && (addr_low < TOTAL_LEN);
    assign accept    = (state == LOAD) && wr_q && in_range;
    assign drop      = (state == LOAD) && wr_q && !in_range;
    assign count_inc = (byte_count == 17'h1FFFF) ? byte_count : byte_count + 17'd1;

    // The image check at the falling edge includes a write still in flight
    // in the capture stage, so a write in the last download cycle counts.
    assign count_after = accept ? count_inc : byte_count;
    assign ovf_after   = overflow | drop;
    assign image_ok    = (count_after == TOTAL_LEN) && !ovf_after;
    assign load_entry  = (state_next == LOAD) && (state != LOAD);

    // Region decode of the captured address into a one-hot select and base.
    always_comb begin
        sel_dec     = 4'b1000;
        region_base = BASE3;
        if (addr_low < BASE1) begin
            sel_dec     = 4'b0001;
            region_base = 17'd0;
        end else if (addr_low < BASE2) begin
            sel_dec     = 4'b0010;
            region_base = BASE1;
        end else if (addr_low < BASE3) begin
            sel_dec     = 4'b0100;
            region_base = BASE2;
        end
    end

    assign local_addr = addr_low - region_base;

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a new download wins from every resting state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rise) state_next = LOAD;
            end
            LOAD: begin
                if (fall) state_next = image_ok ? SETTLE : ERR;
            end
            SETTLE: begin
                if (rise) state_next = LOAD;
                else if (!user_reset && (settle_cnt == '0)) state_next = RUN;
            end
            RUN: begin
                if (rise) state_next = LOAD;
                else if (user_reset) state_next = SETTLE;
            end
            ERR: begin
                if (rise) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs: the core only runs in RUN.
    always_comb begin
        core_reset = (state != RUN);
        load_err   = (state == ERR);
    end

    // Byte counter and overflow flag, restarted on every new download.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            byte_count <= '0;
            overflow   <= 1'b0;
        end else if (load_entry) begin
            byte_count <= '0;
            overflow   <= 1'b0;
        end else if (state == LOAD) begin
            byte_count <= count_after;
            overflow   <= ovf_after;
        end
    end

    // load_done is sticky across user resets and cleared by a new download.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            load_done <= 1'b0;
        end else if (load_entry) begin
            load_done <= 1'b0;
        end else if (state_next == RUN) begin
            load_done <= 1'b1;
        end
    end

    // Settle down-counter, reloaded on entry and while user_reset is held.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if ((state_next == SETTLE) && (state != SETTLE)) begin
            settle_cnt <= SETTLE_RELOAD;
        end else if (state == SETTLE) begin
            if (user_reset) begin
                settle_cnt <= SETTLE_RELOAD;
            end else if (settle_cnt != '0) begin
                settle_cnt <= settle_cnt - CW'(1);
            end
        end
    end

    // Registered ROM write port; select is forced to zero between writes.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rom_wr   <= 1'b0;
            rom_sel  <= '0;
            rom_addr <= '0;
            rom_data <= '0;
        end else begin
            rom_wr  <= accept;
            rom_sel <= accept ? sel_dec : 4'b0000;
            if (accept) begin
                rom_addr <= local_addr[15:0];
                rom_data <= dout_q;
            end
        end
    end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb_rom_load_sequencer: randomized downloads against a scoreboard of
// expected ROM writes plus checks of status outputs and release timing.
module tb_rom_load_sequencer;

    localparam logic [16:0] T_BASE1  = 17'h00100;
    localparam logic [16:0] T_BASE2  = 17'h00180;
    localparam logic [16:0] T_BASE3  = 17'h001A0;
    localparam logic [16:0] T_TOTAL  = 17'h001C0;
    localparam int          T_SETTLE = 16;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    logic        clk_sys;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        user_reset;
    logic [3:0]  rom_sel;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_wr;
    logic        core_reset;
    logic        load_done;
    logic        load_err;
    logic [16:0] byte_count;

    wr_exp_t exp_q[$];
    int      errors;
    int      checks;
    bit      model_active;
    int      model_count;
    bit      model_ovf;

    rom_load_sequencer #(
        .BASE1         (T_BASE1),
        .BASE2         (T_BASE2),
        .BASE3         (T_BASE3),
        .TOTAL_LEN     (T_TOTAL),
        .SETTLE_CYCLES (T_SETTLE)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .user_reset     (user_reset),
        .rom_sel        (rom_sel),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_wr         (rom_wr),
        .core_reset     (core_reset),
        .load_done      (load_done),
        .load_err       (load_err),
        .byte_count     (byte_count)
    );

    // Free-running system clock.
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Expected ROM write for a byte: region by address range, offset from region start.
    function automatic wr_exp_t model_write(input int addr, input logic [7:0] d);
        wr_exp_t e;
        int      base;
        if (addr < int'(T_BASE1)) begin
            e.sel = 4'b0001;
            base  = 0;
        end else if (addr < int'(T_BASE2)) begin
            e.sel = 4'b0010;
            base  = int'(T_BASE1);
        end else if (addr < int'(T_BASE3)) begin
            e.sel = 4'b0100;
            base  = int'(T_BASE2);
        end else begin
            e.sel = 4'b1000;
            base  = int'(T_BASE3);
        end
        e.addr = 16'(addr - base);
        e.data = d;
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // One ioctl write strobe; the model records what the ROM port must show.
    task automatic apply_stimulus(input int addr, input logic [7:0] d);
        ioctl_addr = 25'(addr);
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (model_active) begin
            if (addr < int'(T_TOTAL)) begin
                exp_q.push_back(model_write(addr, d));
                if (model_count < 32'h1FFFF) model_count++;
            end else begin
                model_ovf = 1'b1;
            end
        end
        @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
    endtask

    // A complete download of bytes 0..nbytes-1, optionally with one bad address.
    task automatic run_load(input int nbytes, input bit inject, input int bad_addr,
                            input int tail, input bit gaps);
        int cycles;
        bit good;
        ioctl_download = 1'b1;
        model_active   = 1'b1;
        model_count    = 0;
        model_ovf      = 1'b0;
        idle(1);
        check_output("core_reset_on_rise", 32'(core_reset), 32'd1);
        check_output("load_done_clear", 32'(load_done), 32'd0);
        for (int i = 0; i < nbytes; i++) begin
            apply_stimulus(i, 8'($urandom));
            if (inject && i == nbytes / 2) apply_stimulus(bad_addr, 8'($urandom));
            if (gaps && i != nbytes - 1 && $urandom_range(0, 1) == 1) idle(1);
        end
        idle(tail);
        ioctl_download = 1'b0;
        model_active   = 1'b0;
        good = (model_count == int'(T_TOTAL)) && !model_ovf;
        if (good) begin
            cycles = 0;
            while (cycles < 100) begin
                @(posedge clk_sys);
                #1;
                cycles++;
                if (!core_reset) break;
            end
            check_output("release_delay", 32'(cycles), 32'(T_SETTLE + 1));
            check_output("load_done_set", 32'(load_done), 32'd1);
            check_output("load_err_ok", 32'(load_err), 32'd0);
        end else begin
            idle(T_SETTLE + 5);
            check_output("core_reset_err", 32'(core_reset), 32'd1);
            check_output("load_err_set", 32'(load_err), 32'd1);
            check_output("load_done_err", 32'(load_done), 32'd0);
        end
        check_output("byte_count", 32'(byte_count), 32'(model_count));
    endtask

    // Monitor: every ROM write must match the head of the expected queue.
    always @(negedge clk_sys) begin
        wr_exp_t e;
        if (rom_wr === 1'b1) begin
            check_output("rom_wr_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("rom_sel", 32'(rom_sel), 32'(e.sel));
                check_output("rom_addr", 32'(rom_addr), 32'(e.addr));
                check_output("rom_data", 32'(rom_data), 32'(e.data));
            end
        end else begin
            check_output("rom_sel_idle", 32'(rom_sel), 32'd0);
        end
    end

    // Global bound so the bench always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation bound reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_reset_values(input string tag);
        check_output({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check_output({tag, "_rom_wr"}, 32'(rom_wr), 32'd0);
        check_output({tag, "_rom_sel"}, 32'(rom_sel), 32'd0);
        check_output({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check_output({tag, "_rom_data"}, 32'(rom_data), 32'd0);
        check_output({tag, "_load_done"}, 32'(load_done), 32'd0);
        check_output({tag, "_load_err"}, 32'(load_err), 32'd0);
        check_output({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    endtask

    // Main sequence.
    initial begin
        int cycles;
        errors         = 0;
        checks         = 0;
        model_active   = 1'b0;
        model_count    = 0;
        model_ovf      = 1'b0;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        user_reset     = 1'b0;
        idle(3);
        check_reset_values("por");
        reset = 1'b0;
        idle(3);

        $display("[TB] full load with random gaps");
        run_load(int'(T_TOTAL), 1'b0, 0, 3, 1'b1);

        $display("[TB] user_reset pulse in RUN");
        user_reset = 1'b1;
        idle(1);
        check_output("ureset_core_reset", 32'(core_reset), 32'd1);
        check_output("ureset_load_done", 32'(load_done), 32'd1);
        idle(4);
        user_reset = 1'b0;
        cycles = 0;
        while (cycles < 100) begin
            @(posedge clk_sys);
            #1;
            cycles++;
            if (!core_reset) break;
        end
        check_output("ureset_release_delay", 32'(cycles), 32'(T_SETTLE));
        check_output("ureset_load_done_after", 32'(load_done), 32'd1);

        $display("[TB] short load");
        run_load(int'(T_TOTAL) - 1, 1'b0, 0, 2, 1'b1);
        user_reset = 1'b1;
        idle(3);
        user_reset = 1'b0;
        idle(T_SETTLE + 4);
        check_output("err_ignores_ureset_core", 32'(core_reset), 32'd1);
        check_output("err_ignores_ureset_err", 32'(load_err), 32'd1);

        $display("[TB] full load, last write in final download cycle");
        run_load(int'(T_TOTAL), 1'b0, 0, 0, 1'b0);

        $display("[TB] reset during a download");
        ioctl_download = 1'b1;
        model_active   = 1'b1;
        model_count    = 0;
        model_ovf      = 1'b0;
        idle(1);
        for (int i = 0; i < 20; i++) apply_stimulus(i + 200, 8'($urandom));
        idle(3);
        #2;
        reset = 1'b1;
        model_active = 1'b0;
        #1;
        check_reset_values("midload");
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) apply_stimulus(i, 8'($urandom));
        idle(3);
        check_output("post_reset_byte_count", 32'(byte_count), 32'd0);
        check_output("post_reset_core_reset", 32'(core_reset), 32'd1);
        ioctl_download = 1'b0;
        idle(2);

        $display("[TB] overflow write at image length");
        run_load(int'(T_TOTAL), 1'b1, int'(T_TOTAL), 1, 1'b1);

        $display("[TB] overflow write with high address bits");
        run_load(int'(T_TOTAL), 1'b1, 32'h0020005, 1, 1'b1);

        $display("[TB] final full load");
        run_load(int'(T_TOTAL), 1'b0, 0, 1, 1'b1);

        idle(4);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
